// File: rtl/lcd1602_controller.sv
// rtl/lcd1602_controller.sv - HD44780 16x2 LCD write-only driver (8-bit mode)
//
// After reset and ready_i, initialises the LCD, loads NUM_CHARS custom glyphs
// into CGRAM from an internal ROM, then prints codes 0..NUM_CHARS-1 on line 1.
// Every bus write spans two ticks: E high with rs/data driven, then E low with
// rs/data held, so the LCD latches stable data on the falling edge of E.
//
// Ports:
//   clk     in   system clock
//   reset   in   synchronous active-low reset
//   ready_i in   start enable, sampled in IDLE and DONE
//   rs      out  0 = command, 1 = data
//   rw      out  tied 0, write only
//   enable  out  LCD E strobe
//   data    out  LCD DB7..DB0
module lcd1602_controller #(
    parameter int NUM_COMMANDS     = 3,
    parameter int NUM_DATA_ALL     = 56,
    parameter int NUM_DATA_PERCHAR = 8,
    parameter int NUM_CHARS        = 7,
    parameter int COUNT_MAX        = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ready_i,
    output logic       rs,
    output logic       rw,
    output logic       enable,
    output logic [7:0] data
);

    localparam int IDX_W = $clog2(NUM_DATA_ALL + 1);
    localparam int CNT_W = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_CGADDR, S_CGDATA, S_DDADDR, S_CHARS, S_DONE
    } state_t;

    // Smiling face spread over 7 cells: outline, eyes, nose and a mouth
    // curving along the bottom rows. Byte k = glyph k/8, row k%8.
    localparam logic [7:0] ROM [0:55] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h08, 8'h04, 8'h02, 8'h01,
        8'h1F, 8'h00, 8'h06, 8'h06, 8'h00, 8'h10, 8'h0C, 8'h03,
        8'h1F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h1F,
        8'h1F, 8'h00, 8'h00, 8'h04, 8'h04, 8'h00, 8'h00, 8'h1F,
        8'h1F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h1F,
        8'h1F, 8'h00, 8'h0C, 8'h0C, 8'h00, 8'h01, 8'h06, 8'h18,
        8'h10, 8'h08, 8'h04, 8'h02, 8'h02, 8'h04, 8'h08, 8'h10
    };

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             phase_q, phase_d;   // 0: next tick raises E, 1: next tick drops E
    logic             rs_q, rs_d;
    logic             en_q, en_d;
    logic [7:0]       data_q, data_d;

    logic             tick;
    logic             wr_rs;
    logic [7:0]       wr_data;
    logic             wr_last;
    state_t           wr_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            phase_q <= 1'b0;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            rs_q    <= rs_d;
            en_q    <= en_d;
            data_q  <= data_d;
        end
    end

    // Byte to write for the current state/index and where to go after it
    always_comb begin
        wr_rs   = 1'b0;
        wr_data = 8'h00;
        wr_last = 1'b1;
        wr_next = S_DONE;
        case (state_q)
            S_CMD: begin
                case (idx_q)
                    IDX_W'(0): wr_data = 8'h38;
                    IDX_W'(1): wr_data = 8'h0C;
                    default:   wr_data = 8'h01;
                endcase
                wr_last = (idx_q == IDX_W'(NUM_COMMANDS - 1));
                wr_next = S_CGADDR;
            end
            S_CGADDR: begin
                wr_data = 8'h40;
                wr_next = S_CGDATA;
            end
            S_CGDATA: begin
                wr_rs   = 1'b1;
                wr_data = ROM[idx_q];
                wr_last = (idx_q == IDX_W'(NUM_DATA_ALL - 1));
                wr_next = S_DDADDR;
            end
            S_DDADDR: begin
                wr_data = 8'h80;
                wr_next = S_CHARS;
            end
            S_CHARS: begin
                wr_rs   = 1'b1;
                wr_data = 8'(idx_q);
                wr_last = (idx_q == IDX_W'(NUM_CHARS - 1));
                wr_next = S_DONE;
            end
            default: ;
        endcase
    end

    always_comb begin
        tick    = (cnt_q == CNT_W'(COUNT_MAX - 1));
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        state_d = state_q;
        idx_d   = idx_q;
        phase_d = phase_q;
        rs_d    = rs_q;
        en_d    = en_q;
        data_d  = data_q;
        if (tick) begin
            case (state_q)
                S_IDLE: if (ready_i) state_d = S_CMD;
                S_DONE: if (!ready_i) state_d = S_IDLE;
                default: begin
                    if (!phase_q) begin
                        rs_d    = wr_rs;
                        data_d  = wr_data;
                        en_d    = 1'b1;
                        phase_d = 1'b1;
                    end else begin
                        // rs/data held through this tick so they straddle the E fall
                        en_d    = 1'b0;
                        phase_d = 1'b0;
                        if (wr_last) begin
                            state_d = wr_next;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign rs     = rs_q;
    assign rw     = 1'b0;
    assign enable = en_q;
    assign data   = data_q;

endmodule

// File: tb/tb_lcd1602_controller.sv
// tb/tb_lcd1602_controller.sv - self-checking bench for lcd1602_controller
module tb_lcd1602_controller;

    localparam int CM      = 50;
    localparam int NWRITES = 68;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ready_i = 1'b0;
    logic       rs, rw, enable;
    logic [7:0] data;

    always #5 clk = ~clk;

    lcd1602_controller #(
        .NUM_COMMANDS(3), .NUM_DATA_ALL(56), .NUM_DATA_PERCHAR(8),
        .NUM_CHARS(7), .COUNT_MAX(CM)
    ) dut (
        .clk(clk), .reset(reset), .ready_i(ready_i),
        .rs(rs), .rw(rw), .enable(enable), .data(data)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rises = 0;
    logic en_prev = 1'b0;

    logic       cap_rs[$];
    logic [7:0] cap_data[$];
    int         cap_cyc[$];
    logic       exp_rs[$];
    logic [7:0] exp_data[$];

    logic [4:0] glyph [7][8] = '{
        '{5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h04, 5'h02, 5'h01},
        '{5'h1F, 5'h00, 5'h06, 5'h06, 5'h00, 5'h10, 5'h0C, 5'h03},
        '{5'h1F, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h1F},
        '{5'h1F, 5'h00, 5'h00, 5'h04, 5'h04, 5'h00, 5'h00, 5'h1F},
        '{5'h1F, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h1F},
        '{5'h1F, 5'h00, 5'h0C, 5'h0C, 5'h00, 5'h01, 5'h06, 5'h18},
        '{5'h10, 5'h08, 5'h04, 5'h02, 5'h02, 5'h04, 5'h08, 5'h10}
    };

    always @(posedge clk) cyc <= cyc + 1;

    // Record every falling edge of E together with what the LCD would latch
    always @(negedge clk) begin
        if (en_prev && !enable) begin
            cap_rs.push_back(rs);
            cap_data.push_back(data);
            cap_cyc.push_back(cyc);
        end
        if (!en_prev && enable) rises <= rises + 1;
        en_prev <= enable;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_cap();
        cap_rs.delete();
        cap_data.delete();
        cap_cyc.delete();
    endtask

    task automatic wait_edges(input int n, input int budget);
        int t = 0;
        while (cap_rs.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
    endtask

    // Expected write list from the LCD programming sequence
    task automatic build_model();
        logic [7:0] cmds[3] = '{8'h38, 8'h0C, 8'h01};
        foreach (cmds[i]) begin exp_rs.push_back(1'b0); exp_data.push_back(cmds[i]); end
        exp_rs.push_back(1'b0); exp_data.push_back(8'h40);
        for (int k = 0; k < 56; k++) begin
            exp_rs.push_back(1'b1);
            exp_data.push_back({3'b000, glyph[k / 8][k % 8]});
        end
        exp_rs.push_back(1'b0); exp_data.push_back(8'h80);
        for (int c = 0; c < 7; c++) begin
            exp_rs.push_back(1'b1);
            exp_data.push_back(8'(c));
        end
    endtask

    task automatic check_run(input string tag, input int start);
        int n;
        n = cap_rs.size();
        check({tag, "_count"}, n, NWRITES);
        if (n > NWRITES) n = NWRITES;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_rs%0d", tag, i), cap_rs[i], exp_rs[i]);
            check($sformatf("%s_data%0d", tag, i), cap_data[i], exp_data[i]);
            if (i > 0)
                check($sformatf("%s_gap%0d", tag, i), cap_cyc[i] - cap_cyc[i-1], 2 * CM);
        end
        if (n > 0)
            check({tag, "_runtime"}, (cap_cyc[n-1] - start) <= (NWRITES * 2 * CM + 2 * CM), 1);
    endtask

    initial begin
        int k, st;
        build_model();

        // Reset values
        reset = 1'b0; ready_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rs", rs, 0);
        check("rst_en", enable, 0);
        check("rst_data", data, 8'h00);
        check("rst_rw", rw, 0);

        // Idle with ready low: no E activity
        reset = 1'b1;
        clear_cap();
        st = rises;
        repeat (500) @(negedge clk);
        check("idle_rises", rises - st, 0);

        // Full sequence
        st = cyc;
        ready_i = 1'b1;
        wait_edges(NWRITES, 8000);
        check_run("run1", st);
        st = rises;
        repeat (400) @(negedge clk);
        check("done_rises", rises - st, 0);
        check("done_en", enable, 0);
        check("done_rw", rw, 0);

        // Drop ready in DONE for at least one tick, rerun; ready wobble mid-run is ignored
        ready_i = 1'b0;
        repeat ($urandom_range(CM + 1, 3 * CM)) @(negedge clk);
        clear_cap();
        st = cyc;
        ready_i = 1'b1;
        k = $urandom_range(5, 40);
        wait_edges(k, 8000);
        ready_i = 1'b0;
        wait_edges(k + $urandom_range(3, 15), 8000);
        ready_i = 1'b1;
        wait_edges(NWRITES, 8000);
        check_run("run2", st);

        // Reset in the middle of CGDATA
        ready_i = 1'b0;
        repeat (3 * CM) @(negedge clk);
        clear_cap();
        ready_i = 1'b1;
        k = $urandom_range(10, 40);
        wait_edges(4 + k, 8000);
        check("mid_reached", cap_rs.size(), 4 + k);
        repeat ($urandom_range(1, CM / 2)) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_en", enable, 0);
        check("mid_rst_rs", rs, 0);
        check("mid_rst_data", data, 8'h00);
        reset = 1'b1;
        clear_cap();
        st = cyc;
        wait_edges(NWRITES, 8000);
        check_run("run3", st);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
